// File: rtl/piezo_burst_scheduler.sv
// Arbitrates PTP/RTC burst requests, drives a guarded piezo burst, then listens for the echo and timestamps it.
// Optional PIEZO_SCHED_ECHO_SYNC_EN adds a 2-flop synchronizer on iEcho ahead of edge detection.
module piezo_burst_scheduler #(
  parameter int GUARD_CYCLES  = 8,
  parameter int HALF_PERIOD   = 4,
  parameter int LISTEN_CYCLES = 4096
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic        iReqPtp,
  input  logic        iReqRtc,
  output logic        oGntPtp,
  output logic        oGntRtc,
  input  logic [7:0]  iPulses,
  output logic        oTxEnable,
  output logic        oRxEnable,
  output logic        oPiezo,
  input  logic        iEcho,
  input  logic [31:0] iTime,
  output logic [31:0] oEchoTime,
  output logic        oEchoValid,
  output logic        oTimeout,
  output logic        oDone,
  output logic        oBusy
);
  localparam int MAX_GH = (GUARD_CYCLES > HALF_PERIOD) ? GUARD_CYCLES : HALF_PERIOD;
  localparam int MAXC   = (MAX_GH > LISTEN_CYCLES) ? MAX_GH : LISTEN_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, GUARD_TX, BURST, GUARD_RX, LISTEN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    halves_q, halves_d;
  logic [7:0]    pulses_q, pulses_d;
  logic          rtc_last_q, rtc_last_d;
  logic          grab_ptp, grab_rtc, hit, expire;
  logic          echo_cur, echo_prev_q, echo_rise;

  logic          gnt_ptp_q, gnt_ptp_d, gnt_rtc_q, gnt_rtc_d;
  logic          tx_q, tx_d, rx_q, rx_d, piezo_q, piezo_d;
  logic          valid_q, valid_d, timeout_q, timeout_d, done_q, done_d, busy_q, busy_d;
  logic [31:0]   echo_time_q, echo_time_d;

`ifdef PIEZO_SCHED_ECHO_SYNC_EN
  logic echo_s1_q, echo_s2_q;
  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
    end else begin
      echo_s1_q <= iEcho;
      echo_s2_q <= echo_s1_q;
    end
  end
  assign echo_cur = echo_s2_q;
`else
  assign echo_cur = iEcho;
`endif

  // echo_prev_q tracks the echo in every state, so a level already high at LISTEN entry never looks like an edge
  assign echo_rise = echo_cur & ~echo_prev_q;

  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      halves_q    <= '0;
      pulses_q    <= '0;
      rtc_last_q  <= 1'b1;
      echo_prev_q <= 1'b0;
      gnt_ptp_q   <= 1'b0;
      gnt_rtc_q   <= 1'b0;
      tx_q        <= 1'b0;
      rx_q        <= 1'b0;
      piezo_q     <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      echo_time_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halves_q    <= halves_d;
      pulses_q    <= pulses_d;
      rtc_last_q  <= rtc_last_d;
      echo_prev_q <= echo_cur;
      gnt_ptp_q   <= gnt_ptp_d;
      gnt_rtc_q   <= gnt_rtc_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      piezo_q     <= piezo_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      echo_time_q <= echo_time_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    halves_d   = halves_q;
    pulses_d   = pulses_q;
    rtc_last_d = rtc_last_q;
    grab_ptp   = 1'b0;
    grab_rtc   = 1'b0;
    hit        = 1'b0;
    expire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (iReqPtp && (!iReqRtc || rtc_last_q)) grab_ptp = 1'b1;
        else if (iReqRtc)                        grab_rtc = 1'b1;
        if (grab_ptp || grab_rtc) begin
          state_d    = GUARD_TX;
          cnt_d      = CW'(GUARD_CYCLES - 1);
          pulses_d   = iPulses;
          rtc_last_d = grab_rtc;
        end
      end
      GUARD_TX: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (pulses_q == 8'd0) begin
          state_d = GUARD_RX;
          cnt_d   = CW'(GUARD_CYCLES - 1);
        end else begin
          // odd half-period index means oPiezo high, so the burst starts high and ends low
          state_d  = BURST;
          cnt_d    = CW'(HALF_PERIOD - 1);
          halves_d = {pulses_q, 1'b0} - 9'd1;
        end
      end
      BURST: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (halves_q == 9'd0) begin
          state_d = GUARD_RX;
          cnt_d   = CW'(GUARD_CYCLES - 1);
        end else begin
          halves_d = halves_q - 9'd1;
          cnt_d    = CW'(HALF_PERIOD - 1);
        end
      end
      GUARD_RX: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          state_d = LISTEN;
          cnt_d   = CW'(LISTEN_CYCLES - 1);
        end
      end
      LISTEN: begin
        if (echo_rise) begin
          hit     = 1'b1;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          expire  = 1'b1;
          state_d = DONE;
        end else cnt_d = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the state being entered; oDone flags the cycle after the result pulse.
  always_comb begin
    busy_d      = (state_d != IDLE);
    gnt_ptp_d   = grab_ptp | (gnt_ptp_q & busy_d);
    gnt_rtc_d   = grab_rtc | (gnt_rtc_q & busy_d);
    tx_d        = (state_d == GUARD_TX) || (state_d == BURST);
    rx_d        = (state_d == LISTEN);
    piezo_d     = (state_d == BURST) && halves_d[0];
    valid_d     = hit;
    timeout_d   = expire;
    done_d      = (state_q == DONE);
    echo_time_d = hit ? iTime : echo_time_q;
  end

  assign oGntPtp    = gnt_ptp_q;
  assign oGntRtc    = gnt_rtc_q;
  assign oTxEnable  = tx_q;
  assign oRxEnable  = rx_q;
  assign oPiezo     = piezo_q;
  assign oEchoTime  = echo_time_q;
  assign oEchoValid = valid_q;
  assign oTimeout   = timeout_q;
  assign oDone      = done_q;
  assign oBusy      = busy_q;
endmodule

// File: tb/tb_piezo_burst_scheduler.sv
// Directed bench for piezo_burst_scheduler at default parameters, echo synchronizer disabled.
module tb_piezo_burst_scheduler;
  logic        iCLK = 1'b0, iRESETn = 1'b0, iReqPtp = 1'b0, iReqRtc = 1'b0, iEcho = 1'b0;
  logic [7:0]  iPulses = 8'd0;
  logic [31:0] iTime = 32'd0;
  logic        oGntPtp, oGntRtc, oTxEnable, oRxEnable, oPiezo, oEchoValid, oTimeout, oDone, oBusy;
  logic [31:0] oEchoTime;

  int total = 0;
  int bad   = 0;

  piezo_burst_scheduler dut (
    .iCLK(iCLK), .iRESETn(iRESETn), .iReqPtp(iReqPtp), .iReqRtc(iReqRtc),
    .oGntPtp(oGntPtp), .oGntRtc(oGntRtc), .iPulses(iPulses),
    .oTxEnable(oTxEnable), .oRxEnable(oRxEnable), .oPiezo(oPiezo),
    .iEcho(iEcho), .iTime(iTime), .oEchoTime(oEchoTime), .oEchoValid(oEchoValid),
    .oTimeout(oTimeout), .oDone(oDone), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] all_outs();
    return {oGntPtp, oGntRtc, oTxEnable, oRxEnable, oPiezo, oEchoValid, oTimeout, oDone, oBusy, |oEchoTime};
  endfunction

  logic [63:0] txv, rxv, pzv;
  int          n;
  logic        flag;
  logic [1:0]  exp_gnt;

  initial begin
    // reset state
    step(2);
    chk("reset_outs", 64'(all_outs()), 64'd0);
    iRESETn = 1'b1;

    // PTP request, two pulses: 8 guard + 16 burst, 8 quiet, then listen
    iReqPtp = 1'b1; iPulses = 8'd2;
    step();
    iReqPtp = 1'b0; iPulses = 8'd9;
    chk("grant_ptp", 64'({oGntPtp, oGntRtc, oBusy}), 64'b101);
    txv = '0; rxv = '0; pzv = '0;
    for (int i = 0; i < 33; i++) begin
      txv = {txv[62:0], oTxEnable};
      rxv = {rxv[62:0], oRxEnable};
      pzv = {pzv[62:0], oPiezo};
      if (i < 32) step();
    end
    chk("tx_window", txv, 64'h1_FFFF_FE00);
    chk("rx_window", rxv, 64'h1);
    chk("piezo_wave", pzv, 64'h1E1E000);

    // echo 100 cycles into listen
    step(99);
    iEcho = 1'b1; iTime = 32'h12345678;
    step();
    iTime = 32'h0BADBEEF;
    chk("echo_capture", 64'({oEchoValid, oRxEnable, oDone, oGntPtp}), 64'b1001);
    chk("echo_time", 64'(oEchoTime), 64'h12345678);
    step();
    iEcho = 1'b0;
    chk("echo_done", 64'({oEchoValid, oDone, oGntPtp, oBusy}), 64'b0100);
    step();
    chk("done_pulse_end", 64'({oDone, oBusy}), 64'b00);

    // RTC request, zero pulses, echo held high through listen entry
    iReqRtc = 1'b1; iPulses = 8'd0; iEcho = 1'b1;
    step();
    iReqRtc = 1'b0;
    chk("grant_rtc", 64'({oGntPtp, oGntRtc}), 64'b01);
    n = 0; flag = 1'b0;
    while (!oRxEnable && n < 40) begin
      flag |= oPiezo;
      step();
      n++;
    end
    chk("zero_pulse_rx_delay", 64'(n), 64'd16);
    chk("zero_pulse_no_piezo", 64'(flag), 64'd0);
    n = 0; flag = 1'b0;
    while (!oTimeout && n < 5000) begin
      step();
      n++;
      flag |= oEchoValid;
    end
    chk("timeout_delay", 64'(n), 64'd4096);
    chk("high_echo_ignored", 64'({flag, oEchoValid}), 64'd0);
    chk("timeout_keeps_time", 64'(oEchoTime), 64'h12345678);
    step();
    iEcho = 1'b0;
    chk("timeout_done", 64'({oTimeout, oDone, oGntRtc}), 64'b010);

    // both requests held: PTP, RTC, PTP (last grant was RTC)
    iReqPtp = 1'b1; iReqRtc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_gnt = (k == 1) ? 2'b01 : 2'b10;
      step();
      chk("rr_grant", 64'({oGntPtp, oGntRtc}), 64'(exp_gnt));
      n = 0; flag = 1'b0;
      while (!oDone && n < 5000) begin
        if ({oGntPtp, oGntRtc} !== exp_gnt) flag = 1'b1;
        step();
        n++;
      end
      chk("rr_held", 64'({flag, n < 5000}), 64'b01);
    end
    iReqPtp = 1'b0; iReqRtc = 1'b0;
    step();

    // echo on the last listen cycle wins over expiry
    iReqRtc = 1'b1;
    step();
    iReqRtc = 1'b0;
    n = 0;
    while (!oRxEnable && n < 40) begin
      step();
      n++;
    end
    step(4095);
    chk("last_cycle_still_listen", 64'({oRxEnable, oTimeout}), 64'b10);
    iEcho = 1'b1; iTime = 32'hCAFEF00D;
    step();
    iEcho = 1'b0;
    chk("echo_beats_timeout", 64'({oEchoValid, oTimeout}), 64'b10);
    chk("echo_time_last", 64'(oEchoTime), 64'hCAFEF00D);
    step(3);

    // reset during burst: grant PTP so the pointer would favour RTC without reset
    iReqPtp = 1'b1; iPulses = 8'd3;
    step();
    iReqPtp = 1'b0;
    step(9);
    chk("mid_burst", 64'({oTxEnable, oPiezo, oBusy}), 64'b111);
    iRESETn = 1'b0;
    step();
    chk("reset_abort", 64'(all_outs()), 64'd0);
    iRESETn = 1'b1;
    step();
    chk("no_done_after_abort", 64'({oDone, oTimeout, oEchoValid, oBusy}), 64'd0);
    iReqPtp = 1'b1; iReqRtc = 1'b1;
    step();
    iReqPtp = 1'b0; iReqRtc = 1'b0;
    chk("reset_rr_ptp_first", 64'({oGntPtp, oGntRtc}), 64'b10);
    iRESETn = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
